clk_divn_50dc: RTL and testbench

CLK_DIVN_50DC -- requirements
Module: clk_divn_50dc

---
 rtl/clk_div_pkg.sv | 19 +
 rtl/clk_divn_50dc_if.sv | 22 ++
 rtl/clk_div_half_ext.sv | 35 +++
 rtl/clk_divn_50dc.sv | 102 ++++++++++
 tb/tb_clk_divn_50dc.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the 50%-duty divide-by-N clock generator.
// DIV1_BYPASS_EN widens the legal divisor range down to 1.
package clk_div_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

`ifdef DIV1_BYPASS_EN
  localparam int unsigned DIV_MIN = 1;
`else
  localparam int unsigned DIV_MIN = 2;
`endif

  function automatic logic div_legal(input int unsigned val);
    return val >= DIV_MIN;
  endfunction

endpackage

// File: rtl/clk_divn_50dc_if.sv
// Control/status bundle of the divider: run request, divisor load and outputs.
interface clk_divn_50dc_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic             div_err;
  logic             tick;
  logic             clk_out;

  modport master (
    output en, div_val, div_load,
    input  div_ack, div_err, tick, clk_out
  );

  modport slave (
    input  en, div_val, div_load,
    output div_ack, div_err, tick, clk_out
  );
endinterface

// File: rtl/clk_div_half_ext.sv
// Negedge half-cycle extension for odd divisors; with DIV1_BYPASS_EN also
// gates clk through a negedge-registered run flag for N=1.
module clk_div_half_ext (
  input  logic clk,
  input  logic reset_L,
  input  logic pos_q,
  input  logic odd,
`ifdef DIV1_BYPASS_EN
  input  logic bypass,
`endif
  output logic clk_out
);

  logic neg_q;

  always_ff @(negedge clk or negedge reset_L) begin
    if (!reset_L) neg_q <= 1'b0;
    else          neg_q <= odd & pos_q;
  end

`ifdef DIV1_BYPASS_EN
  logic byp_q;

  // Flag only changes while clk is low, so the gated clock cannot glitch.
  always_ff @(negedge clk or negedge reset_L) begin
    if (!reset_L) byp_q <= 1'b0;
    else          byp_q <= bypass;
  end

  assign clk_out = pos_q | neg_q | (clk & byp_q);
`else
  assign clk_out = pos_q | neg_q;
`endif

endmodule

// File: rtl/clk_divn_50dc.sv
// Divide-by-N clock generator with 50% duty, glitch-free divisor updates
// at period wrap, and optional N=1 pass-through (DIV1_BYPASS_EN).
module clk_divn_50dc
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 5
) (
  input  logic           clk,
  input  logic           reset_L,
  clk_divn_50dc_if.slave bus
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [1:0]       state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div_cur, div_nxt, div_pend, half_nxt;
  logic             pend_vld;
  logic             pos_q, pos_nxt;
  logic             ack_q, err_q;
  logic             running, wrap, apply, load_legal;

  assign running    = (state != IDLE);
  assign wrap       = running && (cnt == div_cur - ONE);
  assign apply      = pend_vld && (!running || wrap);
  assign load_legal = div_legal(32'(bus.div_val));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.en) state_nxt = RUN;
      end
      default: begin
        if (wrap) begin
          cnt_nxt   = '0;
          state_nxt = bus.en ? RUN : IDLE;
        end else begin
          cnt_nxt   = cnt + ONE;
          state_nxt = bus.en ? RUN : DRAIN;
        end
      end
    endcase
  end

  // pos_q is computed from next-state values so it lines up with cnt.
  assign div_nxt  = apply ? div_pend : div_cur;
  assign half_nxt = div_nxt >> 1;
  assign pos_nxt  = (state_nxt != IDLE) && (cnt_nxt < half_nxt);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= IDLE;
      cnt      <= '0;
      div_cur  <= DIV_W'(DIV_RST);
      div_pend <= '0;
      pend_vld <= 1'b0;
      pos_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      div_cur <= div_nxt;
      pos_q   <= pos_nxt;
      ack_q   <= apply;
      err_q   <= bus.div_load && !load_legal;
      if (bus.div_load && load_legal) begin
        div_pend <= bus.div_val;
        pend_vld <= 1'b1;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end
    end
  end

`ifdef DIV1_BYPASS_EN
  logic bypass;
  assign bypass = running && (div_cur == ONE);
`endif

  logic clk_mix;

  clk_div_half_ext u_half_ext (
    .clk     (clk),
    .reset_L (reset_L),
    .pos_q   (pos_q),
    .odd     (div_cur[0]),
`ifdef DIV1_BYPASS_EN
    .bypass  (bypass),
`endif
    .clk_out (clk_mix)
  );

  assign bus.clk_out = clk_mix;
  assign bus.div_ack = ack_q;
  assign bus.div_err = err_q;
  assign bus.tick    = (state == RUN) && (cnt == '0);

endmodule

// File: tb/tb_clk_divn_50dc.sv
// Scoreboard bench for clk_divn_50dc: expected tick/ack/err events (with the
// clk_out high time, in half cycles, of the period each tick closes) are queued.
`timescale 1ns/1ps
module tb_clk_divn_50dc;

  localparam int DIV_W  = 8;
  localparam int K_ERR  = 0;
  localparam int K_ACK  = 1;
  localparam int K_TICK = 2;

  typedef struct {
    int kind;
    int cyc;
    int hi;
  } ev_t;

  ev_t   exp_q[$];
  logic  clk = 1'b0;
  logic  reset_L = 1'b1;
  int    cyc = 0;
  int    compared = 0;
  int    mismatched = 0;
  int    half_hi = 0;
  int    s;
  string kname[3] = '{"err", "ack", "tick"};

  clk_divn_50dc_if #(.DIV_W(DIV_W)) bus ();

  clk_divn_50dc #(.DIV_W(DIV_W), .DIV_RST(5)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int kind, input int c, input int hi);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.hi   = hi;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int hi);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL unexpected %s: got event at cycle %0d, required none", kname[kind], cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind == K_TICK && e.hi != hi)) begin
        mismatched++;
        $display("[TB] FAIL event: got %s@%0d hi=%0d, required %s@%0d hi=%0d",
                 kname[kind], cyc, hi, kname[e.kind], e.cyc, e.hi);
      end
    end
  endtask

  // Monitor: events on posedge+1, clk_out high time counted per half cycle.
  initial forever begin
    @(posedge clk);
    #1;
    if (!reset_L) begin
      half_hi = 0;
    end else begin
      if (bus.div_err) observe(K_ERR, 0);
      if (bus.div_ack) observe(K_ACK, 0);
      if (bus.tick) begin
        observe(K_TICK, half_hi);
        half_hi = 0;
      end
      if (bus.clk_out) half_hi++;
    end
    @(negedge clk);
    #1;
    if (!reset_L) half_hi = 0;
    else if (bus.clk_out) half_hi++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic apply_stimulus(input int v);
    bus.div_load = 1'b1;
    bus.div_val  = DIV_W'(v);
    step(1);
    bus.div_load = 1'b0;
  endtask

  task automatic do_reset();
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = '0;
    reset_L      = 1'b0;
    step(2);
    check_output("reset clk_out", int'(bus.clk_out), 0);
    check_output("reset tick", int'(bus.tick), 0);
    check_output("reset div_ack", int'(bus.div_ack), 0);
    check_output("reset div_err", int'(bus.div_err), 0);
    reset_L = 1'b1;
    step(1);
  endtask

  initial begin
    // Default N=5, then asynchronous reset while clk_out is high.
    do_reset();
    s = cyc;
    bus.en = 1'b1;
    push(K_TICK, s + 1, 0);
    push(K_TICK, s + 6, 5);
    push(K_TICK, s + 11, 5);
    push(K_TICK, s + 16, 5);
    step(17);
    check_output("clk_out high before reset", int'(bus.clk_out), 1);
    reset_L = 1'b0;
    #1;
    check_output("clk_out async clear", int'(bus.clk_out), 0);

    // Load 6 mid-period: current period completes at 5, then 3/3.
    do_reset();
    s = cyc;
    bus.en = 1'b1;
    push(K_TICK, s + 1, 0);
    push(K_TICK, s + 6, 5);
    push(K_ACK, s + 11, 0);
    push(K_TICK, s + 11, 5);
    push(K_TICK, s + 17, 6);
    push(K_TICK, s + 23, 6);
    step(7);
    apply_stimulus(6);
    step(16);

    // Two loads in one period: latest (4) wins, single ack.
    do_reset();
    s = cyc;
    bus.en = 1'b1;
    push(K_TICK, s + 1, 0);
    push(K_ACK, s + 6, 0);
    push(K_TICK, s + 6, 5);
    push(K_TICK, s + 10, 4);
    push(K_TICK, s + 14, 4);
    step(2);
    apply_stimulus(7);
    apply_stimulus(4);
    step(11);

    // Illegal divisors raise div_err and leave the period at 5.
    do_reset();
    s = cyc;
    bus.en = 1'b1;
    push(K_TICK, s + 1, 0);
    push(K_ERR, s + 3, 0);
`ifndef DIV1_BYPASS_EN
    push(K_ERR, s + 4, 0);
`endif
    push(K_TICK, s + 6, 5);
    push(K_TICK, s + 11, 5);
    step(2);
    apply_stimulus(0);
`ifndef DIV1_BYPASS_EN
    apply_stimulus(1);
`else
    step(1);
`endif
    step(8);

    // Extremes: N=255 (odd, widest) then N=2.
    do_reset();
    s = cyc;
    bus.en = 1'b1;
    push(K_TICK, s + 1, 0);
    push(K_ACK, s + 6, 0);
    push(K_TICK, s + 6, 5);
    push(K_ACK, s + 261, 0);
    push(K_TICK, s + 261, 255);
    push(K_TICK, s + 263, 2);
    push(K_TICK, s + 265, 2);
    step(1);
    apply_stimulus(255);
    step(5);
    apply_stimulus(2);
    step(258);

    // Load 8 in IDLE, run, drop en at cnt=1: full period then clk_out stays low.
    do_reset();
    s = cyc;
    push(K_ACK, s + 2, 0);
    push(K_TICK, s + 3, 0);
    push(K_TICK, s + 20, 8);
    apply_stimulus(8);
    step(1);
    bus.en = 1'b1;
    step(2);
    bus.en = 1'b0;
    step(11);
    check_output("idle clk_out after drain", int'(bus.clk_out), 0);
    check_output("idle tick after drain", int'(bus.tick), 0);
    step(4);
    bus.en = 1'b1;
    step(2);

`ifdef DIV1_BYPASS_EN
    // N=1 pass-through: tick every running cycle, one high half per cycle.
    do_reset();
    s = cyc;
    push(K_ACK, s + 2, 0);
    push(K_TICK, s + 3, 0);
    push(K_TICK, s + 4, 0);
    push(K_TICK, s + 5, 1);
    push(K_TICK, s + 6, 1);
    apply_stimulus(1);
    step(1);
    bus.en = 1'b1;
    step(4);
    bus.en = 1'b0;
    step(2);
`endif

    check_output("events outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
